bj_hand_collector: RTL and testbench
====================================

Name: bj_hand_collector

Overview:
- Consumer end of the card-dealer interface. Issues single-cycle `request_card_o` pulses to the card dealer, captures the returned 8-bit card after a fixed latency, and accumulates a blackjack hand value with soft-ace handling.
- Sits between the player control logic (deal, hit, stand) and the dealer's `request_card_i`/`card_to_send_o` pair.

Parameters:
- CARD_LATENCY, 2, clock cycles from the `request_card_o` pulse to the cycle in which `card_i` is sampled (1..7).
- MAX_CARDS, 11, maximum cards held; hits beyond this are ignored.
- MAX_RETRY, 3, consecutive invalid cards tolerated per request before `error_o` is asserted.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- deal_i  in  1  pulse: start a new hand (two cards).
- hit_i  in  1  pulse: request one more card.
- stand_i  in  1  pulse: freeze the hand.
- card_i  in  8  card from dealer; [3:0] rank 1..13 (1=Ace, 11..13=J/Q/K), [5:4] suit, [7:6] ignored.
- request_card_o  out  1  one-cycle request pulse to the dealer.
- last_card_o  out  8  most recently accepted card.
- card_count_o  out  4  cards in hand.
- hand_value_o  out  5  best hand value, 0..31.
- soft_o  out  1  an Ace is currently counted as 11.
- busy_o  out  1  request in flight.
- ready_o  out  1  awaiting hit/stand.
- bust_o  out  1  hand_value > 21.
- blackjack_o  out  1  two-card 21.
- stood_o  out  1  player stood.
- error_o  out  1  retry limit exceeded.

Behaviour:
- **Reset** (`rst_i`=0, asynchronous): state=IDLE. All outputs 0; `last_card_o`=8'h00. Internal hard_sum, ace_count, retry and latency counter are 0. Reset mid-request abandons the request; a late card is never sampled.
- **States:** IDLE, REQ, WAIT, ACCEPT, READY, BUST, STOOD, ERROR.
- **IDLE:**
  - `deal_i` → clear hand registers; pending=2; go to REQ.
  - `hit_i` and `stand_i` are ignored.
- **REQ** (one cycle): `request_card_o`=1; latency counter loads CARD_LATENCY-1; go to WAIT.
- **WAIT:** decrement the counter; at 0, sample `card_i` on that edge; go to ACCEPT. With CARD_LATENCY=1, sampling occurs on the edge following the REQ cycle. `busy_o`=1 in REQ, WAIT and ACCEPT.
- **ACCEPT** (one cycle):
  - Rank 0 or rank > 13 is invalid. retry+1. If retry reaches MAX_RETRY → ERROR; otherwise → REQ. The hand is not changed.
  - A valid card:
    - sets `last_card_o`=card and clears retry;
    - increments `card_count_o`;
    - adds points to hard_sum: rank 1 → 1, 2..10 → rank, 11..13 → 10;
    - increments ace_count if rank=1;
    - decrements pending.
  - Then, in priority order:
    - pending>0 → REQ;
    - value>21 → BUST;
    - else → READY.
- **Value arithmetic:**
  - hard_sum is a 6-bit saturating register.
  - hand_value = hard_sum+10 if ace_count>0 and hard_sum≤11; otherwise hard_sum. Result saturates at 31.
  - `soft_o`=1 exactly when the +10 is applied.
  - All value outputs are registered and update in the cycle after ACCEPT.
- **READY:** `ready_o`=1.
  - `hit_i` with count<MAX_CARDS → pending=1, REQ.
  - `hit_i` with count=MAX_CARDS is ignored.
  - `stand_i` → STOOD.
  - Simultaneous `hit_i` and `stand_i`: stand wins.
  - `deal_i` restarts the hand as from IDLE.
- **`blackjack_o`**: set when the hand reaches count=2 with value=21. Cleared only by `deal_i` or reset.
- **Terminal states:**
  - BUST: `bust_o`=1.
  - STOOD: `stood_o`=1.
  - ERROR: `error_o`=1.
  - All three hold until `deal_i`, which clears flags and restarts. `hit_i`/`stand_i` are ignored.
- **Busy behaviour:** while `busy_o`=1, `deal_i`, `hit_i` and `stand_i` are ignored (no queuing).
- **Request spacing:** `request_card_o` is never high in two consecutive cycles. Minimum spacing between requests is CARD_LATENCY+2 cycles.

Test Plan:
1. Reset, then `deal_i`, dealer returns 8'h0A then 8'h01 → two request pulses 4 cycles apart (CARD_LATENCY=2); final hand_value=21, `soft_o`=1, `blackjack_o`=1, `ready_o`=1, card_count=2.
2. Deal 8'h0D, 8'h06, then hit returns 8'h07 → value 16 then 23; `bust_o`=1; subsequent `hit_i` produces no request.
3. Deal 8'h01, 8'h01, hit 8'h09 → value 12 soft, then 21 soft; hit 8'h05 → 16 hard, `soft_o`=0.
4. Dealer returns rank 0 three times in a row → three requests, then `error_o`=1 and hand unchanged; a following `deal_i` clears `error_o`.
5. In READY, assert `hit_i`+`stand_i` in the same cycle → `stood_o`=1, no request. Then assert `rst_i`=0 during a WAIT of a new deal → all outputs 0 immediately, and the card presented later is not captured.
6. Eleven hits of 8'h01 after a deal of 8'h02, 8'h02 → card_count stops at 11; the extra hit is ignored; value = 4 + 9 aces = 13 hard.

Source files
------------

// File: rtl/bj_hand_collector.sv
// Consumer side of the card-dealer link: pulses request_card_o, samples card_i a
// fixed latency later and keeps a blackjack hand total with soft-ace handling.
module bj_hand_collector #(
  parameter int CARD_LATENCY = 2,
  parameter int MAX_CARDS    = 11,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       deal_i,
  input  logic       hit_i,
  input  logic       stand_i,
  input  logic [7:0] card_i,
  output logic       request_card_o,
  output logic [7:0] last_card_o,
  output logic [3:0] card_count_o,
  output logic [4:0] hand_value_o,
  output logic       soft_o,
  output logic       busy_o,
  output logic       ready_o,
  output logic       bust_o,
  output logic       blackjack_o,
  output logic       stood_o,
  output logic       error_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    ACCEPT = 3'd3,
    READY  = 3'd4,
    BUST   = 3'd5,
    STOOD  = 3'd6,
    ERROR  = 3'd7
  } state_t;

  localparam logic [2:0] LAT_LOAD  = 3'(CARD_LATENCY - 1);
  localparam logic [3:0] CARD_MAX  = 4'(MAX_CARDS);
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] lat_cnt;
  logic [7:0] card_q;
  logic [1:0] pending;
  logic [3:0] retry;
  logic [5:0] hard_sum;
  logic [3:0] ace_count;

  logic       start_hand;
  logic       load_lat;
  logic       sample;
  logic       take_card;
  logic       reject_card;
  logic       hit_go;

  logic [3:0] rank;
  logic [3:0] points;
  logic       card_ok;
  logic [6:0] hard_add;
  logic [5:0] hard_nxt;
  logic [3:0] aces_nxt;
  logic [3:0] count_nxt;
  logic [3:0] retry_nxt;
  logic [1:0] pending_nxt;
  logic       soft_nxt;
  logic [6:0] value_raw;
  logic [4:0] value_nxt;

  // Hand arithmetic for the captured card, as it would look once accepted.
  always_comb begin
    rank        = card_q[3:0];
    card_ok     = (rank != 4'd0) && (rank <= 4'd13);
    points      = (rank >= 4'd10) ? 4'd10 : rank;
    hard_add    = {1'b0, hard_sum} + {3'b000, points};
    hard_nxt    = hard_add[6] ? 6'h3F : hard_add[5:0];
    aces_nxt    = ace_count + {3'b000, (rank == 4'd1)};
    count_nxt   = card_count_o + 4'd1;
    retry_nxt   = retry + 4'd1;
    pending_nxt = pending - 2'd1;
    soft_nxt    = (aces_nxt != 4'd0) && (hard_nxt <= 6'd11);
    value_raw   = {1'b0, hard_nxt} + (soft_nxt ? 7'd10 : 7'd0);
    value_nxt   = (value_raw > 7'd31) ? 5'd31 : value_raw[4:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control inputs are only looked at in IDLE, READY and the terminal states,
  // so anything pulsed while a request is in flight is simply dropped.
  always_comb begin
    state_nxt      = state;
    start_hand     = 1'b0;
    load_lat       = 1'b0;
    sample         = 1'b0;
    take_card      = 1'b0;
    reject_card    = 1'b0;
    hit_go         = 1'b0;
    request_card_o = 1'b0;
    busy_o         = 1'b0;
    ready_o        = 1'b0;
    bust_o         = 1'b0;
    stood_o        = 1'b0;
    error_o        = 1'b0;
    case (state)
      IDLE: begin
        if (deal_i) begin
          start_hand = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        request_card_o = 1'b1;
        busy_o         = 1'b1;
        load_lat       = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        busy_o = 1'b1;
        if (lat_cnt == 3'd0) begin
          sample    = 1'b1;
          state_nxt = ACCEPT;
        end
      end
      ACCEPT: begin
        busy_o = 1'b1;
        if (!card_ok) begin
          reject_card = 1'b1;
          state_nxt   = (retry_nxt >= RETRY_LIM) ? ERROR : REQ;
        end else begin
          take_card = 1'b1;
          if (pending_nxt != 2'd0) begin
            state_nxt = REQ;
          end else if (value_nxt > 5'd21) begin
            state_nxt = BUST;
          end else begin
            state_nxt = READY;
          end
        end
      end
      READY: begin
        ready_o = 1'b1;
        if (deal_i) begin
          start_hand = 1'b1;
          state_nxt  = REQ;
        end else if (stand_i) begin
          state_nxt = STOOD;
        end else if (hit_i && (card_count_o < CARD_MAX)) begin
          hit_go    = 1'b1;
          state_nxt = REQ;
        end
      end
      BUST, STOOD, ERROR: begin
        bust_o  = (state == BUST);
        stood_o = (state == STOOD);
        error_o = (state == ERROR);
        if (deal_i) begin
          start_hand = 1'b1;
          state_nxt  = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lat_cnt      <= 3'd0;
      card_q       <= 8'h00;
      pending      <= 2'd0;
      retry        <= 4'd0;
      hard_sum     <= 6'd0;
      ace_count    <= 4'd0;
      card_count_o <= 4'd0;
      last_card_o  <= 8'h00;
      hand_value_o <= 5'd0;
      soft_o       <= 1'b0;
      blackjack_o  <= 1'b0;
    end else begin
      if (load_lat) begin
        lat_cnt <= LAT_LOAD;
      end else if ((state == WAIT) && (lat_cnt != 3'd0)) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      if (sample) begin
        card_q <= card_i;
      end
      if (start_hand) begin
        pending      <= 2'd2;
        retry        <= 4'd0;
        hard_sum     <= 6'd0;
        ace_count    <= 4'd0;
        card_count_o <= 4'd0;
        last_card_o  <= 8'h00;
        hand_value_o <= 5'd0;
        soft_o       <= 1'b0;
        blackjack_o  <= 1'b0;
      end else if (take_card) begin
        pending      <= pending_nxt;
        retry        <= 4'd0;
        hard_sum     <= hard_nxt;
        ace_count    <= aces_nxt;
        card_count_o <= count_nxt;
        last_card_o  <= card_q;
        hand_value_o <= value_nxt;
        soft_o       <= soft_nxt;
        if ((count_nxt == 4'd2) && (value_nxt == 5'd21)) begin
          blackjack_o <= 1'b1;
        end
      end else if (reject_card) begin
        retry <= retry_nxt;
      end else if (hit_go) begin
        pending <= 2'd1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_bj_hand_collector.sv
// Bench for bj_hand_collector: directed scenarios plus random play, checked against
// a hand-level model that scores the list of accepted cards.
module tb_bj_hand_collector;

  localparam int LAT  = 2;
  localparam int MAXC = 11;
  localparam int MAXR = 3;

  localparam int K_DEAL  = 0;
  localparam int K_HIT   = 1;
  localparam int K_STAND = 2;
  localparam int K_BOTH  = 3;

  localparam int S_IDLE  = 0;
  localparam int S_READY = 1;
  localparam int S_BUST  = 2;
  localparam int S_STOOD = 3;
  localparam int S_ERR   = 4;

  localparam logic [7:0] JUNK = 8'hCE;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       deal_i;
  logic       hit_i;
  logic       stand_i;
  logic [7:0] card_i;
  logic       request_card_o;
  logic [7:0] last_card_o;
  logic [3:0] card_count_o;
  logic [4:0] hand_value_o;
  logic       soft_o;
  logic       busy_o;
  logic       ready_o;
  logic       bust_o;
  logic       blackjack_o;
  logic       stood_o;
  logic       error_o;
  logic [2:0] state_o;

  bj_hand_collector #(
    .CARD_LATENCY(LAT),
    .MAX_CARDS   (MAXC),
    .MAX_RETRY   (MAXR)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .deal_i        (deal_i),
    .hit_i         (hit_i),
    .stand_i       (stand_i),
    .card_i        (card_i),
    .request_card_o(request_card_o),
    .last_card_o   (last_card_o),
    .card_count_o  (card_count_o),
    .hand_value_o  (hand_value_o),
    .soft_o        (soft_o),
    .busy_o        (busy_o),
    .ready_o       (ready_o),
    .bust_o        (bust_o),
    .blackjack_o   (blackjack_o),
    .stood_o       (stood_o),
    .error_o       (error_o),
    .state_o       (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];     // cards the dealer will hand out, in request order
  logic [7:0] script_q[$];  // fixed cards for the next operation, random otherwise

  int req_cnt      = 0;
  int cyc          = 0;
  int last_req_cyc = -100;
  int last_gap     = 0;
  int gap_viol     = 0;

  int         m_hand[$];
  int         m_st;
  bit         m_bj;
  logic [7:0] m_last;
  int         m_reqs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Dealer: card appears on card_i only in the cycle it must be sampled.
  initial begin : dealer
    int dly;
    logic [7:0] held;
    dly    = -1;
    held   = JUNK;
    card_i = JUNK;
    forever begin
      @(negedge clk);
      cyc++;
      if (dly > 0) begin
        dly--;
        if (dly == 0) card_i = held;
      end else if (dly == 0) begin
        card_i = JUNK;
        dly    = -1;
      end
      if (request_card_o === 1'b1) begin
        req_cnt++;
        last_gap = cyc - last_req_cyc;
        if (last_gap < LAT + 2) gap_viol++;
        last_req_cyc = cyc;
        held = (exp_q.size() > 0) ? exp_q.pop_front() : JUNK;
        dly  = LAT;
      end
    end
  end

  // reference model
  function automatic int m_hard();
    int s = 0;
    foreach (m_hand[i]) s += (m_hand[i] > 10) ? 10 : m_hand[i];
    return s;
  endfunction

  function automatic bit m_soft();
    bit ace = 1'b0;
    foreach (m_hand[i]) if (m_hand[i] == 1) ace = 1'b1;
    return ace && (m_hard() <= 11);
  endfunction

  function automatic int m_value();
    int v = m_hard() + (m_soft() ? 10 : 0);
    return (v > 31) ? 31 : v;
  endfunction

  function automatic logic [7:0] gen_card();
    logic [7:0] c;
    if (script_q.size() > 0) return script_q.pop_front();
    c = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 5) == 0) begin
      c[3:0] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'(13 + $urandom_range(1, 2));
    end else begin
      c[3:0] = 4'($urandom_range(1, 13));
    end
    return c;
  endfunction

  task automatic m_fetch(input int need);
    int retry = 0;
    int r;
    logic [7:0] c;
    while (need > 0) begin
      c = gen_card();
      exp_q.push_back(c);
      m_reqs++;
      r = int'(c[3:0]);
      if (r >= 1 && r <= 13) begin
        m_hand.push_back(r);
        m_last = c;
        retry  = 0;
        need--;
        if (m_hand.size() == 2 && m_value() == 21) m_bj = 1'b1;
      end else begin
        retry++;
        if (retry == MAXR) begin
          m_st = S_ERR;
          return;
        end
      end
    end
    m_st = (m_value() > 21) ? S_BUST : S_READY;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   request_card_o, 0);
    check({tag, "_last"},  last_card_o, 0);
    check({tag, "_count"}, card_count_o, 0);
    check({tag, "_value"}, hand_value_o, 0);
    check({tag, "_soft"},  soft_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_ready"}, ready_o, 0);
    check({tag, "_bust"},  bust_o, 0);
    check({tag, "_bj"},    blackjack_o, 0);
    check({tag, "_stood"}, stood_o, 0);
    check({tag, "_error"}, error_o, 0);
  endtask

  task automatic compare_all(input string tag, input int req0);
    check({tag, "_reqs"},  req_cnt - req0, m_reqs);
    check({tag, "_count"}, card_count_o, m_hand.size());
    check({tag, "_value"}, hand_value_o, m_value());
    check({tag, "_soft"},  soft_o, m_soft());
    check({tag, "_bj"},    blackjack_o, m_bj);
    check({tag, "_ready"}, ready_o, m_st == S_READY);
    check({tag, "_bust"},  bust_o, m_st == S_BUST);
    check({tag, "_stood"}, stood_o, m_st == S_STOOD);
    check({tag, "_error"}, error_o, m_st == S_ERR);
    check({tag, "_req"},   request_card_o, 0);
    if (m_hand.size() > 0) check({tag, "_last"}, last_card_o, m_last);
    check({tag, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // driver: one control pulse, optional stray pulses mid-request, then settle
  task automatic op(input string tag, input int kind, input bit noise);
    int req0;
    int budget;
    req0   = req_cnt;
    m_reqs = 0;
    case (kind)
      K_DEAL: begin
        m_hand.delete();
        m_bj = 1'b0;
        m_fetch(2);
      end
      K_HIT: if (m_st == S_READY && m_hand.size() < MAXC) m_fetch(1);
      default: if (m_st == S_READY) m_st = S_STOOD;
    endcase
    script_q.delete();
    @(negedge clk);
    deal_i  = (kind == K_DEAL);
    hit_i   = (kind == K_HIT) || (kind == K_BOTH);
    stand_i = (kind == K_STAND) || (kind == K_BOTH);
    @(negedge clk);
    deal_i  = 1'b0;
    hit_i   = 1'b0;
    stand_i = 1'b0;
    if (noise && m_reqs > 0) begin
      @(negedge clk);
      deal_i  = 1'($urandom_range(0, 1));
      hit_i   = 1'($urandom_range(0, 1));
      stand_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      deal_i  = 1'b0;
      hit_i   = 1'b0;
      stand_i = 1'b0;
    end
    budget = 500;
    while (busy_o !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_timeout"}, budget == 0, 0);
    @(negedge clk);
    compare_all(tag, req0);
  endtask

  initial begin : main
    int r0;
    int sel;
    int kind;
    rst_i   = 1'b0;
    deal_i  = 1'b0;
    hit_i   = 1'b0;
    stand_i = 1'b0;
    m_st    = S_IDLE;
    m_bj    = 1'b0;
    m_last  = 8'h00;
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_i = 1'b1;

    op("idle_hit", K_HIT, 1'b0);
    op("idle_stand", K_STAND, 1'b0);

    // blackjack: ten then ace
    script_q = '{8'h0A, 8'h01};
    op("t1_deal", K_DEAL, 1'b0);
    check("t1_gap", last_gap, LAT + 2);
    check("t1_value", hand_value_o, 21);

    // bust, then hits are dead
    script_q = '{8'h0D, 8'h06};
    op("t2_deal", K_DEAL, 1'b0);
    script_q = '{8'h07};
    op("t2_hit", K_HIT, 1'b0);
    check("t2_bust", bust_o, 1);
    op("t2_hit_dead", K_HIT, 1'b0);

    // two aces, soft totals collapsing to hard
    script_q = '{8'h01, 8'h01};
    op("t3_deal", K_DEAL, 1'b0);
    script_q = '{8'h09};
    op("t3_hit1", K_HIT, 1'b0);
    script_q = '{8'h05};
    op("t3_hit2", K_HIT, 1'b0);
    check("t3_value", hand_value_o, 16);

    // retry exhaustion on deal and on hit
    script_q = '{8'h00, 8'h00, 8'h00};
    op("t4_deal_err", K_DEAL, 1'b0);
    op("t4_hit_dead", K_HIT, 1'b0);
    script_q = '{8'h2A, 8'h13};
    op("t4_redeal", K_DEAL, 1'b0);
    script_q = '{8'h30, 8'h0E, 8'h0F};
    op("t4_hit_err", K_HIT, 1'b0);
    check("t4_kept", hand_value_o, 13);

    // stand beats hit, then reset in the middle of a request
    script_q = '{8'h05, 8'h06};
    op("t5_deal", K_DEAL, 1'b0);
    op("t5_both", K_BOTH, 1'b0);
    r0 = req_cnt;
    exp_q.delete();
    exp_q.push_back(8'h05);
    @(negedge clk);
    deal_i = 1'b1;
    @(negedge clk);
    deal_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_zero("t5_rst");
    @(negedge clk);
    rst_i = 1'b1;
    repeat (6) @(negedge clk);
    check_zero("t5_after");
    check("t5_reqs", req_cnt - r0, 1);
    exp_q.delete();
    m_hand.delete();
    m_st = S_IDLE;
    m_bj = 1'b0;

    // card limit
    script_q = '{8'h02, 8'h02};
    op("t6_deal", K_DEAL, 1'b0);
    for (int i = 0; i < 11; i++) begin
      script_q = '{8'h01};
      op($sformatf("t6_hit%0d", i), K_HIT, 1'b0);
    end
    check("t6_count", card_count_o, 11);
    check("t6_value", hand_value_o, 13);

    // random play
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 99);
      if (m_st == S_READY) begin
        kind = (sel < 55) ? K_HIT : (sel < 70) ? K_STAND : (sel < 78) ? K_BOTH : K_DEAL;
      end else begin
        kind = (sel < 70) ? K_DEAL : (sel < 85) ? K_HIT : K_STAND;
      end
      op($sformatf("rnd%0d", i), kind, $urandom_range(0, 3) == 0);
    end

    check("req_spacing", gap_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
